port_stream_bridge: RTL and testbench
=====================================

// Module: port_stream_bridge
// PURPOSE
//  External-side endpoint of the core's memory-mapped port interface.
//  Software pushes 32-bit words over two CPU output ports (data + control) with a toggle handshake.
//  The bridge buffers the words in a FIFO and presents them as a valid/ready stream to downstream logic.
//  Handshake and FIFO status return to software on one CPU input port.
//  The bridge sits beside the core in the top level, in the same clock domain as the core.
// PARAMETERS
//  FIFO_DEPTH_LOG2  3  FIFO depth = 2**FIFO_DEPTH_LOG2 words; legal range 1..7
// PORTS
//  clock        in   1   system clock; all state updates on the rising edge
//  reset        in   1   asynchronous, active-high; clears all state
//  cpuDataOut   in   32  from the core's data output port (e.g. portAOutput); the word to enqueue
//  cpuCtrlOut   in   32  from the core's control output port (e.g. portBOutput)
//                         [0] = request toggle (reqT), [1] = flush level, [31:2] ignored
//  cpuStatusIn  out  32  to the core's status input port (e.g. portAInput)
//                         [0] = ackT, [1] = full, [2] = empty, [15:8] = count, all other bits 0
//  streamData   out  32  FIFO head word
//  streamValid  out  1   head word is valid
//  streamReady  in   1   downstream accepts the head word
// BEHAVIOUR
//  Reset (asynchronous, active-high):
//   - ackT=0, FIFO pointers=0, count=0.
//   - streamValid=0, streamData=0.
//   - cpuStatusIn = 32'h0000_0004 (empty set).
//  Request detection:
//   - A request is pending while cpuCtrlOut[0] != ackT.
//   - Software writes cpuDataOut first, then flips the request toggle.
//  Push:
//   - Condition: request pending, flush=0, and a slot is free.
//   - A slot is free when count < DEPTH, or a pop occurs in the same cycle.
//   - On the push edge, cpuDataOut is written at the write pointer and ackT flips.
//   - The new ackT is visible on cpuStatusIn the next cycle (1-cycle latency).
//   - At most one push per request. A request is never accepted twice.
//  Full:
//   - The request stays pending; ackT is not flipped and data is not sampled.
//   - Acceptance happens on the first cycle the push condition holds.
//   - cpuDataOut is sampled in that cycle, not earlier.
//  Stream output (first-word fall-through):
//   - streamValid = (count != 0); streamData = mem[readPointer].
//   - Pop on streamValid && streamReady.
//   - streamData is held stable while streamValid && !streamReady.
//   - Pushing into an empty FIFO raises streamValid on the next cycle. No same-cycle bypass.
//  Simultaneous push and pop: count is unchanged, both pointers advance.
//  Pointers: FIFO_DEPTH_LOG2 bits, wrap modulo DEPTH.
//  Count: FIFO_DEPTH_LOG2+1 bits, zero-extended into [15:8].
//  Flush (cpuCtrlOut[1]=1):
//   - Pointers and count clear on the next edge; streamValid drops the following cycle.
//   - A flush overrides any push or pop in the same cycle.
//   - A pending request is not accepted while flush=1. It is accepted after flush returns to 0.
//  Status flags: full = (count == DEPTH); empty = (count == 0). Both are registered and derived from count.
//  Reset mid-operation: FIFO contents are discarded and ackT returns to 0.
//   - If reqT=1 after reset, that is a new pending request and is accepted.
//   - Software must re-sync by reading ackT after reset.
//  Memory contents are not reset. Only the pointers and count define validity.
// TESTING
//  1. Reset -> cpuStatusIn=32'h4, streamValid=0. Data=32'hDEADBEEF, flip reqT 0->1, streamReady=0
//     -> next cycle ackT=1, count=1, streamValid=1, streamData=32'hDEADBEEF.
//  2. DEPTH=8, streamReady=0, push 8 words 1..8 -> full=1, count=8.
//     9th toggle with data=9 -> ackT held.
//     Raise streamReady 1 cycle -> word 1 pops, 9 is accepted the same edge, count stays 8.
//  3. Push 20 words while streamReady toggles pseudo-randomly -> output order 1..20 exactly.
//     Pointers wrap twice; no loss or duplication.
//  4. Hold reqT constant for 50 cycles after an accept -> count does not change (no double push).
//  5. Count=5, set flush=1 with a request pending -> count=0, empty=1, streamValid=0, ackT unchanged.
//     Clear flush -> the pending request is accepted next cycle, count=1.
//  6. Assert reset during a stall, with count=3 and streamValid=1 -> all outputs return to reset values immediately (async).
//     reqT=1 held -> accepted on the first cycle after reset release.

Source files
------------

// File: rtl/port_stream_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : port_stream_bridge
//  Description : External-side endpoint of the core's memory-mapped ports.
//                Software writes a word on cpuDataOut, then flips the request
//                toggle in cpuCtrlOut[0]. The word is queued in a FIFO and
//                offered downstream as a first-word-fall-through valid/ready
//                stream. Handshake and FIFO state are reported on cpuStatusIn.
//  Ports       : clock, reset (async, active-high)
//                cpuDataOut  [31:0] in  word to enqueue
//                cpuCtrlOut  [31:0] in  [0] request toggle, [1] flush level
//                cpuStatusIn [31:0] out [0] ackT, [1] full, [2] empty,
//                                       [15:8] count, other bits 0
//                streamData  [31:0] out FIFO head word (0 when empty)
//                streamValid        out head word valid
//                streamReady        in  downstream accepts head word
//  Revision    : 1.0  initial release
// ============================================================================
module port_stream_bridge #(
  parameter int FIFO_DEPTH_LOG2 = 3  // depth = 2**FIFO_DEPTH_LOG2, 1..7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpuDataOut,
  input  logic [31:0] cpuCtrlOut,
  output logic [31:0] cpuStatusIn,
  output logic [31:0] streamData,
  output logic        streamValid,
  input  logic        streamReady
);

  localparam int                       DEPTH     = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = FIFO_DEPTH_LOG2'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE = (FIFO_DEPTH_LOG2 + 1)'(1);

  logic [31:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q,  count_d;
  logic                       ack_q,    ack_d;

  logic w_req_pending;
  logic w_flush;
  logic w_pop;
  logic w_slot_free;
  logic w_push;
  logic w_full;
  logic w_empty;
  logic w_unused_ctrl;

  assign w_flush       = cpuCtrlOut[1];
  assign w_req_pending = cpuCtrlOut[0] != ack_q;
  assign w_empty       = (count_q == '0);
  assign w_full        = (count_q == DEPTH_CNT);

  // Flush wins over any pop: the FIFO is cleared instead of advanced.
  assign w_pop         = !w_empty && streamReady && !w_flush;
  // A full FIFO still has room when the head leaves on this same edge.
  assign w_slot_free   = !w_full || w_pop;
  assign w_push        = w_req_pending && !w_flush && w_slot_free;

  // Upper control bits carry no meaning for this bridge.
  assign w_unused_ctrl = ^cpuCtrlOut[31:2];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ack_d    = ack_q;
    if (w_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        ack_d    = ~ack_q;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
    end
  end

  // Storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      mem[wr_ptr_q] <= cpuDataOut;
    end
  end

  assign streamValid = !w_empty;
  // Gate the head so an empty FIFO shows zero rather than stale storage.
  assign streamData  = w_empty ? 32'h0 : mem[rd_ptr_q];
  assign cpuStatusIn = {16'h0, 8'(count_q), 5'b0, w_empty, w_full, ack_q};

endmodule
`default_nettype wire

// File: tb/tb_port_stream_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_port_stream_bridge
//  Description : Self-checking bench for port_stream_bridge (DEPTH = 8).
//                Expected stream words are queued when a request is driven and
//                compared as the DUT pops them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_port_stream_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cpuDataOut;
  logic [31:0] cpuCtrlOut;
  logic [31:0] cpuStatusIn;
  logic [31:0] streamData;
  logic        streamValid;
  logic        streamReady;

  logic        req;
  logic        flush;
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] exp_status;
  } vec_t;
  vec_t tbl[8];

  port_stream_bridge #(.FIFO_DEPTH_LOG2(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpuDataOut (cpuDataOut),
    .cpuCtrlOut (cpuCtrlOut),
    .cpuStatusIn(cpuStatusIn),
    .streamData (streamData),
    .streamValid(streamValid),
    .streamReady(streamReady)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_ctrl();
    cpuCtrlOut = {30'h0, flush, req};
  endtask

  // One clock: the pop (if any) is judged at the falling edge, where the
  // inputs are stable, then time advances to just after the rising edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clock);
    if (streamValid && streamReady && !flush && !reset) begin
      pops++;
      if (sb.size() == 0) begin
        chk("unexpected_pop", streamData, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        chk("stream_word", streamData, e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    cpuDataOut = d;
    req        = ~req;
    drive_ctrl();
    sb.push_back(d);
  endtask

  task automatic wait_ack(input int budget, input bit rnd);
    int n = 0;
    while (cpuStatusIn[0] != req && n < budget) begin
      if (rnd) streamReady = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("ack_wait", {31'h0, cpuStatusIn[0]}, {31'h0, req});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    streamReady = 1'b1;
    while (streamValid && n < budget) begin
      tick();
      n++;
    end
    streamReady = 1'b0;
    chk("drain_empty", {31'h0, cpuStatusIn[2]}, 32'h1);
    chk("drain_sb", sb.size(), 0);
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    req         = 1'b0;
    flush       = 1'b0;
    streamReady = 1'b0;
    cpuDataOut  = 32'h0;
    drive_ctrl();
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Table: push k (1-based) leaves ack = k%2, count = k, full at k == 8.
    for (int i = 0; i < 8; i++) begin
      tbl[i].data       = 32'(i + 1);
      tbl[i].exp_status = {16'h0, 8'(i + 1), 5'b0, 1'b0, (i == 7), ((i + 1) % 2 == 1)};
    end

    // ---- 1: reset state and first push ----
    apply_reset();
    chk("reset_status", cpuStatusIn, 32'h0000_0004);
    chk("reset_valid", {31'h0, streamValid}, 32'h0);
    chk("reset_data", streamData, 32'h0);
    send(32'hDEAD_BEEF);
    tick();
    chk("t1_status", cpuStatusIn, 32'h0000_0101);
    chk("t1_valid", {31'h0, streamValid}, 32'h1);
    chk("t1_data", streamData, 32'hDEAD_BEEF);
    drain(20);

    // ---- 2: fill to full, blocked 9th request, pop+push same edge ----
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].data);
      tick();
      chk("t2_fill_status", cpuStatusIn, tbl[i].exp_status);
    end
    chk("t2_head", streamData, 32'h1);
    send(32'h9);
    tick();
    tick();
    chk("t2_blocked", cpuStatusIn, 32'h0000_0802);
    chk("t2_head_stable", streamData, 32'h1);
    streamReady = 1'b1;
    tick();
    streamReady = 1'b0;
    chk("t2_popush", cpuStatusIn, 32'h0000_0803);
    chk("t2_new_head", streamData, 32'h2);
    drain(30);

    // ---- 3: 20 words with random backpressure ----
    apply_reset();
    pops = 0;
    for (int i = 1; i <= 20; i++) begin
      send(32'(i));
      wait_ack(200, 1'b1);
    end
    drain(50);
    chk("t3_pops", pops, 20);

    // ---- 4: held request is not accepted twice ----
    apply_reset();
    send(32'hA4A4_0004);
    for (int i = 0; i < 50; i++) tick();
    chk("t4_status", cpuStatusIn, 32'h0000_0101);
    drain(10);

    // ---- 5: flush with request pending ----
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      send(32'h50 + 32'(i));
      tick();
    end
    chk("t5_count5", cpuStatusIn, 32'h0000_0501);
    cpuDataOut = 32'h5555_AAAA;
    req        = ~req;
    flush      = 1'b1;
    drive_ctrl();
    sb.delete();
    tick();
    chk("t5_flushed", cpuStatusIn, 32'h0000_0005);
    chk("t5_valid", {31'h0, streamValid}, 32'h0);
    tick();
    tick();
    chk("t5_held", cpuStatusIn, 32'h0000_0005);
    flush = 1'b0;
    drive_ctrl();
    sb.push_back(32'h5555_AAAA);
    tick();
    chk("t5_accept", cpuStatusIn, 32'h0000_0100);
    drain(10);

    // ---- 6: asynchronous reset during a stall ----
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      send(32'h60 + 32'(i));
      tick();
    end
    chk("t6_count3", cpuStatusIn, 32'h0000_0301);
    chk("t6_valid", {31'h0, streamValid}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_status", cpuStatusIn, 32'h0000_0004);
    chk("t6_async_valid", {31'h0, streamValid}, 32'h0);
    chk("t6_async_data", streamData, 32'h0);
    sb.delete();
    cpuDataOut = 32'hCAFE_0006;
    sb.push_back(32'hCAFE_0006);
    @(posedge clock);
    #1;
    chk("t6_in_reset", cpuStatusIn, 32'h0000_0004);
    #2;
    reset = 1'b0;
    tick();
    chk("t6_accept", cpuStatusIn, 32'h0000_0101);
    chk("t6_data", streamData, 32'hCAFE_0006);
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
